// File: rtl/uart_rx_loader.sv
// Frames bytes from a UART receiver into loader commands: byte writes to memory over a
// valid/ready port and a jump request, with timeout, checksum and overrun checking.
module uart_rx_loader #(
   parameter int unsigned TIMEOUT_CLKS = 100000,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Mem_Valid,
   output logic [31:0] o_Mem_Addr,
   output logic [7:0]  o_Mem_Data,
   input  logic        i_Mem_Ready,
   output logic        o_Jump_Valid,
   output logic [31:0] o_Jump_Addr,
   output logic        o_Busy,
   output logic        o_Error,
   output logic [1:0]  o_Error_Code
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned TMO_W  = 32;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_JUMP  = 8'h02;

   localparam logic [1:0] ERR_CSUM    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_CSUM
   } state_t;

   state_t              state_q, state_d;
   logic                is_jump_q, is_jump_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [7:0]          csum_q, csum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]          mem_data_q, mem_data_d;
   logic                jump_valid_q, jump_valid_d;
   logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;
   logic                busy_q, busy_d;
   logic                error_q, error_d;
   logic [1:0]          error_code_q, error_code_d;

   logic [7:0]          csum_next;
   logic [LEN_W-1:0]    len_next;
   logic                abort;
   logic [1:0]          abort_code;

   // Next-state and output computation
   always_comb begin
      state_d      = state_q;
      is_jump_d    = is_jump_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      len_d        = len_q;
      idx_d        = idx_q;
      csum_d       = csum_q;
      tmo_d        = tmo_q;
      mem_valid_d  = mem_valid_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      jump_valid_d = 1'b0;
      jump_addr_d  = jump_addr_q;
      error_d      = 1'b0;
      error_code_d = error_code_q;
      abort        = 1'b0;
      abort_code   = ERR_OVERRUN;

      csum_next = csum_q + i_Rx_Byte;
      len_next  = {i_Rx_Byte, len_q[15:8]};

      // Inter-byte timer; held while a write waits on slow memory
      if (state_q == S_IDLE || i_Rx_DV) begin
         tmo_d = '0;
      end else if (!mem_valid_q) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      if (mem_valid_q && i_Mem_Ready) begin
         mem_valid_d = 1'b0;
         if (state_q == S_DATA && idx_q == len_q) begin
            state_d = S_CSUM;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
               state_d   = S_CMD;
               csum_d    = '0;
               cnt_d     = '0;
               addr_d    = '0;
               len_d     = '0;
               idx_d     = '0;
               is_jump_d = 1'b0;
            end
         end
         S_CMD: begin
            if (i_Rx_DV) begin
               csum_d = csum_next;
               if (i_Rx_Byte == CMD_WRITE) begin
                  is_jump_d = 1'b0;
                  state_d   = S_ADDR;
               end else if (i_Rx_Byte == CMD_JUMP) begin
                  is_jump_d = 1'b1;
                  state_d   = S_ADDR;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_OVERRUN;
               end
            end
         end
         S_ADDR: begin
            if (i_Rx_DV) begin
               csum_d = csum_next;
               addr_d = {i_Rx_Byte, addr_q[31:8]};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  cnt_d   = '0;
                  state_d = is_jump_q ? S_CSUM : S_LEN;
               end
            end
         end
         S_LEN: begin
            if (i_Rx_DV) begin
               csum_d = csum_next;
               len_d  = len_next;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd1) begin
                  cnt_d   = '0;
                  state_d = (len_next == '0) ? S_CSUM : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (i_Rx_DV && !mem_valid_q && idx_q != len_q) begin
               csum_d      = csum_next;
               mem_valid_d = 1'b1;
               mem_addr_d  = addr_q + ADDR_W'(idx_q);
               mem_data_d  = i_Rx_Byte;
               idx_d       = idx_q + LEN_W'(1);
            end
         end
         S_CSUM: begin
            if (i_Rx_DV) begin
               csum_d  = csum_next;
               state_d = S_IDLE;
               if (csum_next == 8'h00) begin
                  if (is_jump_q) begin
                     jump_valid_d = 1'b1;
                     jump_addr_d  = addr_q;
                  end
               end else begin
                  error_d      = 1'b1;
                  error_code_d = ERR_CSUM;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new byte arriving before the previous write drained, or a stalled frame
      if (i_Rx_DV && mem_valid_q) begin
         abort      = 1'b1;
         abort_code = ERR_OVERRUN;
      end else if (state_q != S_IDLE && !i_Rx_DV && !mem_valid_q && tmo_q == TMO_LAST) begin
         abort      = 1'b1;
         abort_code = ERR_TIMEOUT;
      end

      if (abort) begin
         state_d      = S_IDLE;
         mem_valid_d  = 1'b0;
         jump_valid_d = 1'b0;
         error_d      = 1'b1;
         error_code_d = abort_code;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q      <= S_IDLE;
         is_jump_q    <= 1'b0;
         cnt_q        <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         jump_valid_q <= 1'b0;
         jump_addr_q  <= '0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
         error_code_q <= '0;
      end else begin
         state_q      <= state_d;
         is_jump_q    <= is_jump_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         csum_q       <= csum_d;
         tmo_q        <= tmo_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         jump_valid_q <= jump_valid_d;
         jump_addr_q  <= jump_addr_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
         error_code_q <= error_code_d;
      end
   end

   assign o_Mem_Valid  = mem_valid_q;
   assign o_Mem_Addr   = mem_addr_q;
   assign o_Mem_Data   = mem_data_q;
   assign o_Jump_Valid = jump_valid_q;
   assign o_Jump_Addr  = jump_addr_q;
   assign o_Busy       = busy_q;
   assign o_Error      = error_q;
   assign o_Error_Code = error_code_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: write/jump frames, checksum failure, timeout,
// overrun, asynchronous reset and address wrap.
module tb_uart_rx_loader;

   localparam int unsigned TMO = 50;
   localparam int unsigned GAP = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_ready;
   logic        jump_valid;
   logic [31:0] jump_addr;
   logic        busy;
   logic        error;
   logic [1:0]  error_code;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int          jump_cnt = 0;
   int          err_cnt  = 0;
   logic [7:0]  frame[$];

   always #5 clk = ~clk;

   uart_rx_loader #(.TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
      .i_Clock      (clk),
      .i_Reset_n    (rst_n),
      .i_Rx_DV      (rx_dv),
      .i_Rx_Byte    (rx_byte),
      .o_Mem_Valid  (mem_valid),
      .o_Mem_Addr   (mem_addr),
      .o_Mem_Data   (mem_data),
      .i_Mem_Ready  (mem_ready),
      .o_Jump_Valid (jump_valid),
      .o_Jump_Addr  (jump_addr),
      .o_Busy       (busy),
      .o_Error      (error),
      .o_Error_Code (error_code)
   );

   // Log accepted writes and count pulse cycles
   always @(posedge clk) begin
      if (mem_valid && mem_ready) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_data);
      end
      if (jump_valid) jump_cnt++;
      if (error) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv   = 1'b0;
   endtask

   task automatic send_frame();
      foreach (frame[i]) begin
         send_byte(frame[i]);
         repeat (GAP) @(negedge clk);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      jump_cnt = 0;
      err_cnt  = 0;
   endtask

   initial begin
      int cyc;
      rst_n     = 1'b0;
      rx_dv     = 1'b0;
      rx_byte   = 8'h00;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_valid", 32'(mem_valid), 32'h0);
      check("reset_code", 32'(error_code), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: write frame with good checksum, plus stray non-sync bytes first
      clear_log();
      frame = '{8'h00, 8'h37, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00,
                8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h86};
      send_frame();
      check("t1_nwr", 32'(wr_addr.size()), 32'd3);
      if (wr_addr.size() == 3) begin
         check("t1_a0", wr_addr[0], 32'h0000_1000);
         check("t1_d0", 32'(wr_data[0]), 32'h11);
         check("t1_a1", wr_addr[1], 32'h0000_1001);
         check("t1_d1", 32'(wr_data[1]), 32'h22);
         check("t1_a2", wr_addr[2], 32'h0000_1002);
         check("t1_d2", 32'(wr_data[2]), 32'h33);
      end
      check("t1_err", 32'(err_cnt), 32'd0);
      check("t1_busy", 32'(busy), 32'h0);
      check("t1_jump", 32'(jump_cnt), 32'd0);

      // 2: jump frame
      clear_log();
      frame = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEA};
      send_frame();
      check("t2_jcnt", 32'(jump_cnt), 32'd1);
      check("t2_jaddr", jump_addr, 32'h1234_5678);
      check("t2_err", 32'(err_cnt), 32'd0);

      // 3: write frame with bad checksum still writes
      clear_log();
      frame = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00,
                8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      send_frame();
      check("t3_nwr", 32'(wr_addr.size()), 32'd3);
      check("t3_err", 32'(err_cnt), 32'd1);
      check("t3_code", 32'(error_code), 32'h1);
      check("t3_jump", 32'(jump_cnt), 32'd0);
      check("t3_busy", 32'(busy), 32'h0);

      // 4: stall after the second address byte
      clear_log();
      frame = '{8'hA5, 8'h01, 8'h00};
      send_frame();
      send_byte(8'h10);
      check("t4_busy_mid", 32'(busy), 32'h1);
      cyc = 0;
      while (!error && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t4_delay", 32'(cyc), 32'd50);
      check("t4_code", 32'(error_code), 32'h2);
      @(negedge clk);
      check("t4_err_pulse", 32'(err_cnt), 32'd1);
      check("t4_busy", 32'(busy), 32'h0);
      clear_log();
      frame = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEA};
      send_frame();
      check("t4_jcnt", 32'(jump_cnt), 32'd1);
      check("t4_jaddr", jump_addr, 32'h1234_5678);

      // 5: memory stalled, second data byte overruns
      clear_log();
      mem_ready = 1'b0;
      frame = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00};
      send_frame();
      send_byte(8'hD1);
      check("t5_valid", 32'(mem_valid), 32'h1);
      check("t5_waddr", mem_addr, 32'h0000_2000);
      repeat (GAP) @(negedge clk);
      send_byte(8'hD2);
      check("t5_err", 32'(error), 32'h1);
      check("t5_code", 32'(error_code), 32'h3);
      check("t5_valid_drop", 32'(mem_valid), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_nwr", 32'(wr_addr.size()), 32'd0);

      // 6: asynchronous reset mid-write, then address wrap
      frame = '{8'hA5, 8'h01, 8'h00, 8'h30, 8'h00, 8'h00, 8'h04, 8'h00};
      send_frame();
      send_byte(8'hAA);
      check("t6_valid_pre", 32'(mem_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_valid", 32'(mem_valid), 32'h0);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_code", 32'(error_code), 32'h0);
      check("t6_jaddr", jump_addr, 32'h0);
      check("t6_maddr", mem_addr, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      clear_log();
      frame = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'hAA, 8'h55, 8'h02};
      send_frame();
      check("t6_nwr", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("t6_a0", wr_addr[0], 32'hFFFF_FFFF);
         check("t6_d0", 32'(wr_data[0]), 32'hAA);
         check("t6_a1", wr_addr[1], 32'h0000_0000);
         check("t6_d1", 32'(wr_data[1]), 32'h55);
      end
      check("t6_err", 32'(err_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
